// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) line-burst arbiter for a
// single backing memory port.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   i_req_valid/addr/ready       instruction-side line read request
//   i_rdata/i_rvalid/i_rlast     instruction-side read beats
//   d_req_valid/we/addr/ready    data-side line read (we=0) or write (we=1)
//   d_wdata/d_wready             data-side write beat and its acceptance
//   d_rdata/d_rvalid/d_rlast     data-side read beats
//   mem_cmd_valid/we/addr/ready  command channel to memory (line-aligned)
//   mem_wdata/wvalid/wready      write beat channel to memory
//   mem_rdata/mem_rvalid         read beat channel from memory
//   busy                         arbiter is not idle
//   grant_d                      current/last owner is the data side
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN  defined: ties go to the side not granted last
//                           (first tie after reset goes to data).
//                           undefined: data side always wins ties.
//
// Request acceptance (req_ready) and the beat channels are combinational so
// that a request is taken in its first IDLE cycle and beats pass straight
// through without added latency.
module mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  input  logic [WIDTH-1:0] i_req_addr,
  output logic             i_req_ready,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_rvalid,
  output logic             i_rlast,
  input  logic             d_req_valid,
  input  logic             d_req_we,
  input  logic [WIDTH-1:0] d_req_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_req_ready,
  output logic             d_wready,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_rvalid,
  output logic             d_rlast,
  output logic             mem_cmd_valid,
  output logic             mem_cmd_we,
  output logic [WIDTH-1:0] mem_cmd_addr,
  input  logic             mem_cmd_ready,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wvalid,
  input  logic             mem_wready,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic             busy,
  output logic             grant_d
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] addr_q;
  logic             we_q;
  logic             pick_d;
  logic             accept;
  logic             beat;
  logic             last_beat;

  // Arbitration: a lone requester always wins; ties resolved by build option.
  always_comb begin
    pick_d = d_req_valid;
    if (d_req_valid && i_req_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_d = !grant_d;
`else
      pick_d = 1'b1;
`endif
    end
  end

  // Reset gates acceptance so no ready is seen while rst is low.
  assign accept    = rst && (state == IDLE) && (i_req_valid || d_req_valid);
  assign beat      = ((state == WDATA) && mem_wready) || ((state == RDATA) && mem_rvalid);
  assign last_beat = (beat_cnt == LAST_BEAT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CMD;
      CMD:     if (mem_cmd_ready) state_nxt = we_q ? WDATA : RDATA;
      WDATA:   if (mem_wready && last_beat) state_nxt = IDLE;
      RDATA:   if (mem_rvalid && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch and beat counter; counter clears when the grant enters CMD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      grant_d  <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      addr_q   <= (pick_d ? d_req_addr : i_req_addr) & ALIGN_MASK;
      we_q     <= pick_d && d_req_we;
      grant_d  <= pick_d;
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // Output decode; stray memory strobes outside their data state are ignored.
  always_comb begin
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    i_rdata       = '0;
    i_rvalid      = 1'b0;
    i_rlast       = 1'b0;
    d_rdata       = '0;
    d_rvalid      = 1'b0;
    d_rlast       = 1'b0;
    d_wready      = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wdata     = '0;
    mem_wvalid    = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        i_req_ready = accept && !pick_d;
        d_req_ready = accept && pick_d;
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = we_q;
        mem_cmd_addr  = addr_q;
      end
      WDATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = d_wdata;
        d_wready   = mem_wready;
      end
      RDATA: begin
        if (grant_d) begin
          d_rvalid = mem_rvalid;
          d_rdata  = mem_rvalid ? mem_rdata : '0;
          d_rlast  = mem_rvalid && last_beat;
        end else begin
          i_rvalid = mem_rvalid;
          i_rdata  = mem_rvalid ? mem_rdata : '0;
          i_rlast  = mem_rvalid && last_beat;
        end
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level self-checking bench for mem_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned LW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_valid, i_req_ready, i_rvalid, i_rlast;
  logic [W-1:0] i_req_addr, i_rdata;
  logic         d_req_valid, d_req_we, d_req_ready, d_wready, d_rvalid, d_rlast;
  logic [W-1:0] d_req_addr, d_wdata, d_rdata;
  logic         mem_cmd_valid, mem_cmd_we, mem_cmd_ready;
  logic [W-1:0] mem_cmd_addr, mem_wdata, mem_rdata;
  logic         mem_wvalid, mem_wready, mem_rvalid;
  logic         busy, grant_d;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_d   = 1'b0;  // model: owner of the most recent grant

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_wdata(d_wdata), .d_req_ready(d_req_ready), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_ready(mem_cmd_ready), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .grant_d(grant_d)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tie rule of the arbiter, stated as policy.
  function automatic bit tie_goes_d();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] or_outs();
    return 64'(|{i_req_ready, i_rdata, i_rvalid, i_rlast, d_req_ready, d_wready,
                 d_rdata, d_rvalid, d_rlast, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
                 mem_wdata, mem_wvalid, busy, grant_d});
  endfunction

  task automatic drive_idle();
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_we = 0; d_req_addr = '0;
    d_wdata = '0; mem_cmd_ready = 0; mem_wready = 0; mem_rdata = '0; mem_rvalid = 0;
  endtask

  // One complete transaction. mode: 0 random strobes, 1 always, 2 toggling 1,0,...
  // abort_after >= 0 pulls reset once that many beats have been delivered.
  task automatic run_txn(input bit iv, input logic [W-1:0] ia, input bit dv, input bit dwe,
                         input logic [W-1:0] da, input int stall, input int mode,
                         input logic [W-1:0] base, input int abort_after);
    bit           exp_d, exp_we, strobe;
    logic [W-1:0] exp_addr, own_rd, oth_rd;
    logic         own_rv, own_rl, oth_rv, oth_rl;
    int           n, cyc;
    exp_d    = dv && (!iv || tie_goes_d());
    exp_we   = exp_d && dwe;
    exp_addr = (exp_d ? da : ia) & ~W'(LW * 4 - 1);

    @(negedge clk);
    i_req_valid = iv; i_req_addr = ia; d_req_valid = dv; d_req_we = dwe; d_req_addr = da;
    mem_cmd_ready = 0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    mem_wready = 1'($urandom_range(0, 1));
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("i_req_ready", 64'(i_req_ready), 64'(!exp_d));
    check("d_req_ready", 64'(d_req_ready), 64'(exp_d));
    check("idle_rvalid", 64'({i_rvalid, d_rvalid, i_rdata, d_rdata}), 64'(0));
    check("idle_cmd", 64'({mem_cmd_valid, mem_wvalid}), 64'(0));
    last_d = exp_d;

    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      if (exp_d) d_req_valid = 0; else i_req_valid = 0;
      mem_cmd_ready = (k == stall);
      mem_rvalid = 1'($urandom_range(0, 1)); mem_wready = 1'($urandom_range(0, 1));
      #1;
      check("cmd_valid", 64'(mem_cmd_valid), 64'(1));
      check("cmd_addr", 64'(mem_cmd_addr), 64'(exp_addr));
      check("cmd_we", 64'(mem_cmd_we), 64'(exp_we));
      check("cmd_busy", 64'(busy), 64'(1));
      check("cmd_grant", 64'(grant_d), 64'(exp_d));
      check("cmd_readies", 64'({i_req_ready, d_req_ready}), 64'(0));
      check("cmd_strobes", 64'({i_rvalid, d_rvalid, mem_wvalid}), 64'(0));
    end

    n = 0; cyc = 0;
    while (n < LW && cyc < 200) begin
      @(negedge clk);
      if (abort_after >= 0 && n == abort_after) begin
        rst = 1'b0; mem_rvalid = 1; mem_cmd_ready = 1; mem_wready = 1;
        i_req_valid = 1; d_req_valid = 1;
        #1;
        check("rst_outs_now", or_outs(), 64'(0));
        @(negedge clk); #1;
        check("rst_outs_held", or_outs(), 64'(0));
        drive_idle();
        rst = 1'b1;
        last_d = 1'b0;
        return;
      end
      case (mode)
        1:       strobe = 1'b1;
        2:       strobe = (cyc % 2 == 0);
        default: strobe = ($urandom_range(0, 2) != 0);
      endcase
      mem_cmd_ready = 1'($urandom_range(0, 1));
      if (exp_we) begin
        mem_wready = strobe; d_wdata = base + W'(n);
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end else begin
        mem_rvalid = strobe; mem_rdata = strobe ? base + W'(n) : $urandom;
        mem_wready = 1'($urandom_range(0, 1));
      end
      #1;
      check("data_busy", 64'(busy), 64'(1));
      check("data_cmd", 64'({mem_cmd_valid, i_req_ready, d_req_ready}), 64'(0));
      own_rv = exp_d ? d_rvalid : i_rvalid;  oth_rv = exp_d ? i_rvalid : d_rvalid;
      own_rl = exp_d ? d_rlast  : i_rlast;   oth_rl = exp_d ? i_rlast  : d_rlast;
      own_rd = exp_d ? d_rdata  : i_rdata;   oth_rd = exp_d ? i_rdata  : d_rdata;
      check("other_r", 64'({oth_rv, oth_rl, oth_rd}), 64'(0));
      if (exp_we) begin
        check("wvalid", 64'(mem_wvalid), 64'(1));
        check("wdata", 64'(mem_wdata), 64'(base + W'(n)));
        check("d_wready", 64'(d_wready), 64'(strobe));
        check("wr_no_rvalid", 64'({own_rv, own_rl, own_rd}), 64'(0));
      end else begin
        check("rd_no_w", 64'({mem_wvalid, d_wready}), 64'(0));
        check("rvalid", 64'(own_rv), 64'(strobe));
        check("rdata", 64'(own_rd), strobe ? 64'(base + W'(n)) : 64'(0));
        check("rlast", 64'(own_rl), 64'(strobe && n == LW - 1));
      end
      if (strobe) n++;
      cyc++;
    end
    check("burst_beats", 64'(n), 64'(LW));
    if (mode == 1) check("burst_cycles", 64'(cyc), 64'(LW));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit iv, dv;
    rst = 1'b0;
    drive_idle();
    #1;
    check("reset_outs", or_outs(), 64'(0));
    check("reset_grant", 64'(grant_d), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn(1, 32'h0000_1234, 0, 0, '0, 0, 1, 32'hA0, -1);           // lone I read
    run_txn(0, '0, 1, 1, 32'h0000_0100, 0, 2, 32'h11, -1);           // D write, toggling wready
    run_txn(1, $urandom, 1, 0, 32'h2000_0044, 5, 0, $urandom, -1);   // long command stall
    run_txn(1, 32'h0000_0300, 0, 0, '0, 0, 1, 32'hB0, 2);            // reset mid-burst
    check("post_rst_grant", 64'(grant_d), 64'(0));
    run_txn(1, 32'h0000_0348, 0, 0, '0, 0, 1, 32'hC0, -1);           // full burst after reset
    run_txn(1, $urandom, 1, 0, $urandom, 0, 0, $urandom, -1);        // tie
    run_txn(1, $urandom, 1, 1, $urandom, 1, 0, $urandom, -1);        // tie again

    for (int t = 0; t < 40; t++) begin
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) iv = 1'b1;
      run_txn(iv, $urandom, dv, 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), 0, $urandom, -1);
    end

    @(negedge clk);
    drive_idle();
    #1;
    check("final_idle", 64'({busy, mem_cmd_valid, mem_wvalid}), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
